data_bus_arbiter: RTL
=====================

// Module: data_bus_arbiter
// PURPOSE
//  Two-master arbiter in front of the memory-mapped data bus (memory, FP unit, HEX/SW/LEDR/KEY).
//  M0 = pipeline memory stage, M1 = secondary master (DMA/debug).
//  Round-robin grant, held until the bus signals done; inserts one idle cycle between transactions.
//  A watchdog aborts any transaction that does not finish in time.
// PARAMETERS
//  DATA_W   16   data width of BusIn/BusOut and master data ports
//  ADDR_W   16   address width (top 4 bits select device on the bus)
//  TIMEOUT  255  max grant cycles without DataDone before abort; 0 disables the watchdog
// PORTS
//  Clock      in   1       system clock, all state on posedge
//  Resetn     in   1       asynchronous, active-low reset
//  M0Read     in   1       M0 read request; held until M0Done
//  M0Write    in   1       M0 write request; held until M0Done
//  M0Addr     in   ADDR_W  M0 address; stable while requesting
//  M0WrData   in   DATA_W  M0 write data; stable while requesting
//  M0RdData   out  DATA_W  read data; valid only in the M0Done cycle
//  M0Done     out  1       1-cycle completion pulse to M0
//  M0Err      out  1       with M0Done: transaction aborted by the watchdog
//  M1*        -    -       identical set for M1 (M1Read ... M1Err)
//  ReadData   out  1       bus read strobe
//  WriteData  out  1       bus write strobe
//  DataAddr   out  ADDR_W  bus address
//  BusIn      out  DATA_W  bus write data
//  BusOut     in   DATA_W  bus read data
//  DataDone   in   1       bus completion
//  Grant      out  2       one-hot current owner ({M1,M0}); 00 in IDLE
// BEHAVIOUR
//  Reset (Resetn=0, async):
//   - state=IDLE, rr pointer=M0 preferred, watchdog=0.
//   - All outputs 0: strobes, DataAddr, BusIn, Done, Err, RdData, Grant.
//  States:
//   - IDLE: bus strobes 0. On the clock edge, pick a requester (Read|Write) and go to GNT0 or GNT1.
//     Both requesting -> pick the one the rr pointer prefers. Neither -> stay in IDLE.
//   - GNTx: the bus carries master x's strobes, Addr and WrData combinationally; Grant=x.
//     Read&Write together -> treat as write: WriteData=1, ReadData=0.
//  Completion:
//   - In GNTx with DataDone=1 and x still requesting: MxDone=1 and MxRdData=BusOut, both in the same cycle.
//   - Next state IDLE; rr pointer now prefers the other master.
//  Request dropped while granted (no Read/Write):
//   - Strobes drop in the same cycle; no Done; next state IDLE; rr pointer unchanged.
//  Latency:
//   - Request seen in IDLE -> bus strobe in the next cycle.
//   - Minimum 2 cycles per transaction (1 IDLE + 1 GNT). Back-to-back transactions always pass through IDLE.
//   - That IDLE cycle guarantees devices that toggle done on strobe see a strobe-low cycle.
//  Watchdog (TIMEOUT>0):
//   - Counter clears on GNT entry and increments each GNT cycle with DataDone=0.
//   - In the GNT cycle where count==TIMEOUT-1 and DataDone=0: MxDone=1, MxErr=1, MxRdData=0; next state IDLE; rr advances.
//   - DataDone in that same cycle wins: normal done, Err=0.
//  Non-granted master: Done/Err/RdData are 0. Its request waits; no starvation (rr alternates).
//  Reset asserted mid-transaction: immediate abort to IDLE, no Done pulse.
// TESTING
//  1 M0Read addr 0x0010, DataDone after 2 GNT cycles, BusOut=0xBEEF
//    -> ReadData high for 2 cycles starting 1 cycle after the request; M0Done pulse with M0RdData=0xBEEF.
//  2 M0 and M1 write continuously from reset
//    -> Grant sequence 01,00,10,00,01,...; every transaction gets exactly one Done and an IDLE gap.
//  3 M1Write addr 0x2003 data 0x007F, DataDone=1 immediately
//    -> DataAddr=0x2003, BusIn=0x007F for 1 cycle; M1Done next to it; Grant=00 after.
//  4 TIMEOUT=4, M0Read, DataDone held 0
//    -> M0Done=M0Err=1 in the 4th GNT cycle; then IDLE; pending M1 served next.
//  5 M0 drops Read in the 2nd GNT cycle
//    -> ReadData low that cycle, no M0Done, IDLE next; M0 still preferred if both request.
//  6 Resetn pulsed low mid-GNT1
//    -> all outputs 0 immediately; after release M0 wins a simultaneous request.

Source files
------------

// File: rtl/data_bus_arbiter_if.sv
// Two-master data bus bundle: master request/response handshakes plus the shared device bus.
// slave modport faces the arbiter, master modport faces the requesters and bus devices.
interface data_bus_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              M0Read;
    logic              M0Write;
    logic [ADDR_W-1:0] M0Addr;
    logic [DATA_W-1:0] M0WrData;
    logic [DATA_W-1:0] M0RdData;
    logic              M0Done;
    logic              M0Err;

    logic              M1Read;
    logic              M1Write;
    logic [ADDR_W-1:0] M1Addr;
    logic [DATA_W-1:0] M1WrData;
    logic [DATA_W-1:0] M1RdData;
    logic              M1Done;
    logic              M1Err;

    logic              ReadData;
    logic              WriteData;
    logic [ADDR_W-1:0] DataAddr;
    logic [DATA_W-1:0] BusIn;
    logic [DATA_W-1:0] BusOut;
    logic              DataDone;
    logic [1:0]        Grant;

    modport slave (
        input  M0Read, M0Write, M0Addr, M0WrData,
        output M0RdData, M0Done, M0Err,
        input  M1Read, M1Write, M1Addr, M1WrData,
        output M1RdData, M1Done, M1Err,
        output ReadData, WriteData, DataAddr, BusIn, Grant,
        input  BusOut, DataDone
    );

    modport master (
        output M0Read, M0Write, M0Addr, M0WrData,
        input  M0RdData, M0Done, M0Err,
        output M1Read, M1Write, M1Addr, M1WrData,
        input  M1RdData, M1Done, M1Err,
        input  ReadData, WriteData, DataAddr, BusIn, Grant,
        output BusOut, DataDone
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// Round-robin two-master bus arbiter with watchdog; strobe one cycle after request, Done same cycle as DataDone.
// Masters hold requests until Done; the loser waits, and every transaction is followed by one IDLE cycle.
module data_bus_arbiter #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                Clock,
    input  logic                Resetn,
    data_bus_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state;
    logic              rr_m1;
    logic [WD_W-1:0]   wdog;
    logic [1:0]        grant;

    logic              req0, req1;
    logic              cur_rd, cur_wr, cur_req;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdat;
    logic              done_ok, wd_hit, finish;
    logic [DATA_W-1:0] rd_dat;

    assign req0 = bus.M0Read | bus.M0Write;
    assign req1 = bus.M1Read | bus.M1Write;

    always_comb begin
        cur_rd   = 1'b0;
        cur_wr   = 1'b0;
        cur_addr = '0;
        cur_wdat = '0;
        if (state == GNT0) begin
            cur_rd   = bus.M0Read;
            cur_wr   = bus.M0Write;
            cur_addr = bus.M0Addr;
            cur_wdat = bus.M0WrData;
        end else if (state == GNT1) begin
            cur_rd   = bus.M1Read;
            cur_wr   = bus.M1Write;
            cur_addr = bus.M1Addr;
            cur_wdat = bus.M1WrData;
        end
    end

    assign cur_req = cur_rd | cur_wr;
    assign done_ok = cur_req & bus.DataDone;
    // DataDone in the expiry cycle takes priority over the abort.
    assign wd_hit  = (TIMEOUT > 0) && cur_req && !bus.DataDone && (wdog == WD_W'(TIMEOUT - 1));
    assign finish  = done_ok | wd_hit;
    assign rd_dat  = done_ok ? bus.BusOut : '0;

    // A simultaneous read+write is carried as a write.
    assign bus.WriteData = cur_wr;
    assign bus.ReadData  = cur_rd & ~cur_wr;
    assign bus.DataAddr  = cur_addr;
    assign bus.BusIn     = cur_wdat;
    assign bus.Grant     = grant;

    assign bus.M0Done   = (state == GNT0) & finish;
    assign bus.M0Err    = (state == GNT0) & wd_hit;
    assign bus.M0RdData = (state == GNT0) ? rd_dat : '0;
    assign bus.M1Done   = (state == GNT1) & finish;
    assign bus.M1Err    = (state == GNT1) & wd_hit;
    assign bus.M1RdData = (state == GNT1) ? rd_dat : '0;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
            rr_m1 <= 1'b0;
            wdog  <= '0;
            grant <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 && (!req1 || !rr_m1)) begin
                        state <= GNT0;
                        grant <= 2'b01;
                        wdog  <= '0;
                    end else if (req1) begin
                        state <= GNT1;
                        grant <= 2'b10;
                        wdog  <= '0;
                    end
                end
                default: begin
                    if (!cur_req || finish) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        // A dropped request leaves the preference where it was.
                        if (finish)
                            rr_m1 <= (state == GNT0);
                    end else if (TIMEOUT > 0) begin
                        wdog <= wdog + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
